// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller: coin codes,
// FSM states and the coin value / greedy change helpers.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_20   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_e;

    function automatic logic [4:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 5'd5;
            COIN_10: return 5'd10;
            COIN_20: return 5'd20;
            default: return 5'd0;
        endcase
    endfunction

    // Largest coin not exceeding the amount; credit is always a multiple of 5.
    function automatic logic [1:0] change_pick(input logic [31:0] amount);
        if (amount >= 32'd20) begin
            return COIN_20;
        end else if (amount >= 32'd10) begin
            return COIN_10;
        end else if (amount >= 32'd5) begin
            return COIN_5;
        end else begin
            return COIN_NONE;
        end
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-item stock counters with load-all restock, one-hot decrement and a
// registered sold-out flag vector that always mirrors (stock == 0).
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 dec_i,
    input  logic [NUM_ITEMS-1:0] dec_sel_i,
    output logic [NUM_ITEMS-1:0] sold_out_o
);

    localparam logic [STOCK_W-1:0] INIT_VAL = STOCK_W'(INIT_STOCK);

    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q;
    logic [NUM_ITEMS-1:0] sold_out_d;

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (load_i) begin
                stock_d[i] = INIT_VAL;
            end else if (dec_i && dec_sel_i[i] && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= INIT_VAL;
            end
            sold_out_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out_o = sold_out_q;

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: saturating coin credit, per-item prices and
// stock, and greedy one-coin-per-cycle change return. All outputs registered.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS  = 4,
    parameter int CREDIT_W   = 8,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 15,
    parameter int MAX_CREDIT = 60,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {8'd40, 8'd25, 8'd15, 8'd5}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           money,
    input  logic [NUM_ITEMS-1:0] sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    output logic [1:0]           change,
    output logic [NUM_ITEMS-1:0] item_out,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out,
    output logic                 deny,
    output logic                 coin_reject,
    output logic                 busy
);

    localparam int CW1 = CREDIT_W + 1;

    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [1:0]           change_q, change_d;
    logic [NUM_ITEMS-1:0] item_q, item_d;
    logic                 deny_q, deny_d;
    logic                 reject_q, reject_d;
    logic                 busy_q, busy_d;

    logic                 sel_onehot;
    logic [CREDIT_W-1:0]  price_sel;
    logic [CREDIT_W:0]    coin_sum;
    logic [1:0]           pick_coin;
    logic [CREDIT_W-1:0]  pick_val;
    logic                 accept;
    logic                 coin_blocked;
    logic                 restock_en;

    assign sel_onehot = (sel_item != '0) && ((sel_item & (sel_item - NUM_ITEMS'(1))) == '0);
    assign coin_sum   = {1'b0, credit_q} + CW1'(coin_value(money));
    assign pick_coin  = change_pick(32'(credit_q));
    assign pick_val   = CREDIT_W'(coin_value(pick_coin));

    // Selection is one-hot when it matters, so OR-ing the slices acts as a mux.
    always_comb begin
        price_sel = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel_item[i]) begin
                price_sel = price_sel | PRICE_LIST[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        credit_d     = credit_q;
        change_d     = COIN_NONE;
        item_d       = '0;
        deny_d       = 1'b0;
        reject_d     = 1'b0;
        accept       = 1'b0;
        coin_blocked = 1'b0;
        restock_en   = 1'b0;

        case (state_q)
            IDLE, CREDIT: begin
                if ((state_q == CREDIT) && cancel) begin
                    state_d      = CHANGE;
                    change_d     = pick_coin;
                    credit_d     = credit_q - pick_val;
                    coin_blocked = 1'b1;
                end else if (sel_item != '0) begin
                    if ((state_q == CREDIT) && sel_onehot && ((sel_item & sold_out) == '0)
                        && ({1'b0, credit_q} >= {1'b0, price_sel})) begin
                        accept       = 1'b1;
                        state_d      = VEND;
                        item_d       = sel_item;
                        credit_d     = credit_q - price_sel;
                        coin_blocked = 1'b1;
                    end else begin
                        deny_d = 1'b1;
                    end
                end

                // A coin only counts when no cancel or vend claimed this cycle.
                if (money != COIN_NONE) begin
                    if (coin_blocked || (coin_sum > CW1'(MAX_CREDIT))) begin
                        reject_d = 1'b1;
                    end else begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = CREDIT;
                    end
                end
                restock_en = ~accept;
            end

            VEND, CHANGE: begin
                reject_d = (money != COIN_NONE);
                if (credit_q != '0) begin
                    state_d  = CHANGE;
                    change_d = pick_coin;
                    credit_d = credit_q - pick_val;
                end else begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d == VEND) || (state_d == CHANGE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= COIN_NONE;
            item_q   <= '0;
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            item_q   <= item_d;
            deny_q   <= deny_d;
            reject_q <= reject_d;
            busy_q   <= busy_d;
        end
    end

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK)
    ) u_stock (
        .clk        (clk),
        .rst_n      (reset),
        .load_i     (restock && restock_en),
        .dec_i      (accept),
        .dec_sel_i  (sel_item),
        .sold_out_o (sold_out)
    );

    assign change      = change_q;
    assign item_out    = item_q;
    assign credit      = credit_q;
    assign deny        = deny_q;
    assign coin_reject = reject_q;
    assign busy        = busy_q;

endmodule
